// File: rtl/gray_ptr_rx.sv
`default_nettype none
// ============================================================================
//  Module   : gray_ptr_rx
//  Purpose  : Receive side of a gray-coded FIFO pointer crossing. Brings a
//             foreign-domain gray pointer into clk through a flop chain,
//             decodes it to binary, reports the per-cycle advance and
//             latches a sticky error on any multi-bit gray transition.
//  Ports    : clk       - receive-domain clock, rising edge
//             rst       - asynchronous, active-low reset
//             gray_in   - gray pointer from the foreign domain (async)
//             err_clr   - synchronous clear of seq_err (acts only in ERR)
//             bin_out   - registered binary pointer
//             bin_valid - pipeline holds post-reset data
//             step      - registered (new binary - previous bin_out) mod 2^PTR_W
//             seq_err   - sticky illegal-transition flag
//  Revision : 1.0 - initial release
// ============================================================================
module gray_ptr_rx #(
   parameter int PTR_W       = 5,
   parameter int SYNC_STAGES = 2   // legal range 2..4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PTR_W-1:0] gray_in,
   input  logic             err_clr,
   output logic [PTR_W-1:0] bin_out,
   output logic             bin_valid,
   output logic [PTR_W-1:0] step,
   output logic             seq_err
);

   // FILL lasts SYNC_STAGES+1 edges: the counter runs 0..SYNC_STAGES.
   localparam logic [2:0] c_fill_last = 3'(SYNC_STAGES);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      ERR  = 2'd2
   } state_t;

   state_t                            r_state;
   state_t                            w_next;
   logic [2:0]                        r_fill_cnt;
   logic [SYNC_STAGES-1:0][PTR_W-1:0] r_sync;
   logic [PTR_W-1:0]                  r_gprev;
   logic [PTR_W-1:0]                  w_gs;
   logic [PTR_W-1:0]                  w_bin;
   logic [PTR_W-1:0]                  w_diff;
   logic                              w_viol;

   // Plain flop chain, nothing between stages; stage 0 samples gray_in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], gray_in};
      end
   end

   assign w_gs = r_sync[SYNC_STAGES-1];

   // Binary bit i is the XOR of all gray bits from i up to the MSB.
   always_comb begin
      w_bin = '0;
      for (int i = 0; i < PTR_W; i++) begin
         w_bin[i] = ^(w_gs >> i);
      end
   end

   // More than one bit set in the difference <=> clearing the lowest set
   // bit still leaves something.
   assign w_diff = w_gs ^ r_gprev;
   assign w_viol = (w_diff & (w_diff - 1'b1)) != '0;

   always_comb begin
      w_next = r_state;
      case (r_state)
         FILL:    if (r_fill_cnt == c_fill_last) w_next = RUN;
         RUN:     if (w_viol) w_next = ERR;
         ERR:     if (err_clr && !w_viol) w_next = RUN;   // a new violation beats the clear
         default: w_next = FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= FILL;
         r_fill_cnt <= '0;
         r_gprev    <= '0;
         bin_out    <= '0;
         step       <= '0;
         bin_valid  <= 1'b0;
         seq_err    <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_fill_cnt <= (r_state == FILL) ? 3'(r_fill_cnt + 3'd1) : 3'd0;
         r_gprev    <= w_gs;
         bin_out    <= w_bin;
         // While filling, bin_out still carries reset-era data, so no step.
         step       <= (r_state == FILL) ? '0 : (w_bin - bin_out);
         bin_valid  <= (w_next != FILL);
         seq_err    <= (w_next == ERR);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gray_ptr_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gray_ptr_rx
//  Purpose  : Directed self-checking bench for gray_ptr_rx (PTR_W=5,
//             SYNC_STAGES=2): reset, counting with wrap, slow producer,
//             illegal jumps with error clear / set-wins, mid-run reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gray_ptr_rx;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] gray_in;
   logic       err_clr;
   logic [4:0] bin_out;
   logic       bin_valid;
   logic [4:0] step;
   logic       seq_err;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   gray_ptr_rx #(
      .PTR_W       (5),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .gray_in   (gray_in),
      .err_clr   (err_clr),
      .bin_out   (bin_out),
      .bin_valid (bin_valid),
      .step      (step),
      .seq_err   (seq_err)
   );

   function automatic logic [4:0] gray(input int v);
      return 5'(v ^ (v >> 1));
   endfunction

   // Advance one edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst     = 1'b0;
      gray_in = 5'b00000;
      err_clr = 1'b0;
      tick();
      tick();
      chk("rst_bin",   bin_out,   0);
      chk("rst_step",  step,      0);
      chk("rst_err",   seq_err,   0);
      chk("rst_valid", bin_valid, 0);

      // Release: valid rises exactly on the third edge.
      rst = 1'b1;
      tick();  chk("fill_valid1", bin_valid, 0);
      tick();  chk("fill_valid2", bin_valid, 0);
      tick();  chk("fill_valid3", bin_valid, 1);
      chk("fill_bin",  bin_out, 0);
      chk("fill_step", step,    0);
      chk("fill_err",  seq_err, 0);

      // Count through 0..31, wrap to 0, continue to 3.
      for (int i = 1; i <= 35; i++) begin
         gray_in = gray(i % 32);
         tick();
         if (i >= 3) begin
            chk("cnt_bin",  bin_out, (i - 2) % 32);
            chk("cnt_step", step,    1);
            chk("cnt_err",  seq_err, 0);
         end
      end
      tick();  chk("cnt_tail_bin2", bin_out, 2);  chk("cnt_tail_step2", step, 1);
      tick();  chk("cnt_tail_bin3", bin_out, 3);  chk("cnt_tail_step3", step, 1);

      // Slow producer: one advance every 4 clocks.
      for (int v = 4; v <= 6; v++) begin
         gray_in = gray(v);
         for (int k = 1; k <= 4; k++) begin
            tick();
            chk("slow_bin",  bin_out, (k >= 3) ? v : v - 1);
            chk("slow_step", step,    (k == 3) ? 1 : 0);
            chk("slow_err",  seq_err, 0);
         end
      end

      // Illegal jump 00101 (6) -> 00011 (2): step = 2-6 mod 32 = 28.
      gray_in = 5'b00011;
      tick();  chk("viol_err_e1", seq_err, 0);
      tick();  chk("viol_err_e2", seq_err, 0);
      tick();
      chk("viol_err",  seq_err, 1);
      chk("viol_bin",  bin_out, 2);
      chk("viol_step", step,    28);
      tick();
      chk("viol_sticky", seq_err, 1);
      chk("viol_hold_step", step, 0);
      err_clr = 1'b1;
      tick();  chk("clr_err", seq_err, 0);
      err_clr = 1'b0;
      tick();  chk("clr_stay", seq_err, 0);
      err_clr = 1'b1;                    // clear in RUN does nothing
      tick();  chk("clr_run", seq_err, 0);
      err_clr = 1'b0;

      // Re-enter ERR: 00011 (2) -> 00000 (0), step = 30.
      gray_in = 5'b00000;
      tick();
      tick();  chk("viol2_err_e2", seq_err, 0);
      tick();
      chk("viol2_err",  seq_err, 1);
      chk("viol2_bin",  bin_out, 0);
      chk("viol2_step", step,    30);

      // err_clr lands on the same edge as a fresh violation: set wins.
      gray_in = 5'b00011;
      tick();
      tick();
      err_clr = 1'b1;
      tick();
      chk("setwin_err",  seq_err, 1);
      chk("setwin_bin",  bin_out, 2);
      chk("setwin_step", step,    2);
      err_clr = 1'b0;
      tick();  chk("setwin_sticky", seq_err, 1);
      err_clr = 1'b1;
      tick();  chk("setwin_clr", seq_err, 0);
      err_clr = 1'b0;

      // Walk legally up to 12.
      for (int v = 3; v <= 12; v++) begin
         gray_in = gray(v);
         tick();
      end
      tick();
      tick();
      chk("pre_rst_bin",   bin_out,   12);
      chk("pre_rst_valid", bin_valid, 1);
      chk("pre_rst_err",   seq_err,   0);

      // Mid-cycle asynchronous reset.
      #3;
      rst     = 1'b0;
      gray_in = 5'b00100;                // gray(7)
      #1;
      chk("mid_rst_bin",   bin_out,   0);
      chk("mid_rst_step",  step,      0);
      chk("mid_rst_valid", bin_valid, 0);
      chk("mid_rst_err",   seq_err,   0);
      tick();
      tick();
      rst = 1'b1;
      tick();  chk("refill_valid1", bin_valid, 0);
      tick();  chk("refill_valid2", bin_valid, 0);
      tick();
      chk("refill_valid3", bin_valid, 1);
      chk("refill_bin",    bin_out,   7);
      chk("refill_step",   step,      0);
      chk("refill_err",    seq_err,   0);
      tick();
      chk("refill_hold_bin",  bin_out, 7);
      chk("refill_hold_step", step,    0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
